// File: rtl/seq_pkg.sv
// Shared types and constants for the symbol-string recogniser.
// sym() and the alphabet constants are sized for the default 2-bit, 4-symbol configuration.
package seq_pkg;

  localparam int W_DEF = 2;
  localparam int L_DEF = 4;
  localparam int FW    = $clog2(L_DEF);

  localparam logic [W_DEF-1:0] SYM_A = 2'b00;
  localparam logic [W_DEF-1:0] SYM_B = 2'b01;

  // Symbol k of a flat pattern vector; symbol 0 sits in the low bits.
  function automatic logic [W_DEF-1:0] sym(input logic [L_DEF*W_DEF-1:0] vec, input int k);
    return vec[k*W_DEF +: W_DEF];
  endfunction

endpackage

// File: rtl/seq_detector_sym_history.sv
// Symbol history: D symbols of W bits, oldest at index 0, newest at index D-1.
// The flush input has priority over the shift input.
module sym_history #(
  parameter int W = 2,
  parameter int D = 3
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           shift_en,
  input  logic           flush,
  input  logic [W-1:0]   din,
  output logic [D*W-1:0] hist
);

  logic [D*W-1:0] hist_q;
  logic [D*W-1:0] hist_nxt;

  generate
    if (D == 1) begin : g_single
      assign hist_nxt = din;
    end else begin : g_multi
      assign hist_nxt = {din, hist_q[D*W-1:W]};
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)      hist_q <= '0;
    else if (flush)    hist_q <= '0;
    else if (shift_en) hist_q <= hist_nxt;
  end

  assign hist = hist_q;

endmodule

// File: rtl/seq_detector.sv
// Mealy recogniser for a programmable L-symbol pattern in a qualified symbol stream,
// with overlapping/non-overlapping modes and a saturating match counter.
module seq_detector
  import seq_pkg::*;
#(
  parameter int W  = 2,
  parameter int L  = 4,
  parameter int CW = 8
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic [W-1:0]   x,
  input  logic           x_valid,
  input  logic           load,
  input  logic [L*W-1:0] pattern,
  input  logic           overlap,
  input  logic           clr_count,
  output logic           z,
  output logic [CW-1:0]  match_count,
  output logic           busy
);

  localparam int HW     = (L-1)*W;
  localparam int FILL_W = $clog2(L);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(L-1);

  logic [L*W-1:0]    pat_q;
  logic [HW-1:0]     hist;
  logic [FILL_W-1:0] fill;
  logic [CW-1:0]     cnt_q;
  logic              full, win_hit, shift_en;

  // Full-window compare: repeated symbols in the pattern need no failure links.
  assign full     = (fill == FILL_MAX);
  assign win_hit  = (hist == pat_q[HW-1:0]) && (x == pat_q[L*W-1 -: W]);
  assign z        = x_valid & ~load & full & win_hit;
  assign shift_en = x_valid & ~load & ~(z & ~overlap);

  sym_history #(.W(W), .D(L-1)) u_hist (
    .clock    (clock),
    .reset_n  (reset_n),
    .shift_en (shift_en),
    .flush    (load),
    .din      (x),
    .hist     (hist)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  pat_q <= '0;
    else if (load) pat_q <= pattern;
  end

  // Non-overlap match leaves hist as-is; fill=0 alone keeps it from matching again.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)               fill <= '0;
    else if (load)              fill <= '0;
    else if (x_valid) begin
      if (z && !overlap)        fill <= '0;
      else if (!full)           fill <= fill + FILL_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                 cnt_q <= '0;
    else if (clr_count)           cnt_q <= '0;
    else if (z && (cnt_q != '1))  cnt_q <= cnt_q + CW'(1);
  end

  assign match_count = cnt_q;
  assign busy        = (fill != '0);

endmodule

// File: tb/tb_seq_detector.sv
// Scoreboard bench for seq_detector: stimulus pushes expected z per qualified symbol,
// a negedge monitor pops and compares; counter/busy checks are made directly.
module tb_seq_detector;
  import seq_pkg::*;

  localparam int W  = 2;
  localparam int L  = 4;
  localparam int CW = 2;

  localparam logic [W-1:0] A = SYM_A;
  localparam logic [W-1:0] B = SYM_B;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic [W-1:0]   x = '0;
  logic           x_valid = 1'b0;
  logic           load = 1'b0;
  logic [L*W-1:0] pattern = '0;
  logic           overlap = 1'b0;
  logic           clr_count = 1'b0;
  logic           z;
  logic [CW-1:0]  match_count;
  logic           busy;

  int tests = 0;
  int fails = 0;
  int zidx  = 0;
  bit exp_q[$];

  seq_detector #(.W(W), .L(L), .CW(CW)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .x           (x),
    .x_valid     (x_valid),
    .load        (load),
    .pattern     (pattern),
    .overlap     (overlap),
    .clr_count   (clr_count),
    .z           (z),
    .match_count (match_count),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every qualified symbol cycle presents a z to compare.
  always @(negedge clock) begin
    if (reset_n && x_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL z_underflow: got z=%0d with no expected entry", z);
      end else begin
        chk($sformatf("z[%0d]", zidx), 32'(z), 32'(exp_q.pop_front()));
        zidx++;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic feed(input logic [W-1:0] s, input bit ez);
    x_valid = 1'b1;
    x = s;
    exp_q.push_back(ez);
    tick();
    x_valid = 1'b0;
  endtask

  // Load with a valid symbol present: it must be ignored and z held low.
  task automatic do_load(input logic [L*W-1:0] p);
    load = 1'b1;
    pattern = p;
    x_valid = 1'b1;
    x = B;
    exp_q.push_back(1'b0);
    tick();
    load = 1'b0;
    x_valid = 1'b0;
  endtask

  task automatic do_clr();
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
  endtask

  initial begin
    #2;
    chk("reset_z", 32'(z), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_count", 32'(match_count), 0);
    #10 reset_n = 1'b1;
    tick();

    // Overlapping "abba" over a b b a b b a.
    overlap = 1'b1;
    do_load(8'h14);
    chk("load_busy", 32'(busy), 0);
    feed(A,0); feed(B,0); feed(B,0); feed(A,1); feed(B,0); feed(B,0); feed(A,1);
    chk("ovl_count", 32'(match_count), 2);
    do_clr();
    chk("clr_count", 32'(match_count), 0);

    // Non-overlapping, same stream.
    overlap = 1'b0;
    do_load(8'h14);
    feed(A,0); feed(B,0); feed(B,0); feed(A,1);
    chk("novl_busy_after_match", 32'(busy), 0);
    chk("novl_count_a", 32'(match_count), 1);
    feed(B,0); feed(B,0); feed(A,0);
    chk("novl_count_b", 32'(match_count), 1);
    chk("novl_busy_refill", 32'(busy), 1);

    // Valid gaps hold the history.
    overlap = 1'b1;
    do_clr();
    do_load(8'h14);
    feed(A,0); tick(); feed(B,0); tick(); tick(); feed(B,0); feed(A,1);
    chk("gap_count", 32'(match_count), 1);

    // Reload discards partial history.
    do_load(8'h14);
    feed(A,0); feed(B,0); feed(B,0);
    do_load(8'h05);
    chk("reload_busy", 32'(busy), 0);
    feed(A,0); feed(A,0); feed(B,0); feed(B,0); feed(A,0); feed(A,1);
    chk("reload_count", 32'(match_count), 2);

    // Saturation: five "aaaa" matches on a 2-bit counter.
    do_clr();
    do_load(8'h00);
    feed(A,0); feed(A,0); feed(A,0);
    for (int i = 0; i < 5; i++) feed(A,1);
    chk("sat_count", 32'(match_count), 3);

    // Asynchronous reset mid-stream.
    do_load(8'h14);
    chk("load_keeps_count", 32'(match_count), 3);
    feed(A,0); feed(B,0);
    chk("mid_busy", 32'(busy), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_busy", 32'(busy), 0);
    chk("async_count", 32'(match_count), 0);
    chk("async_z", 32'(z), 0);
    #3 reset_n = 1'b1;
    tick();

    // After reset the pattern is "aaaa" and four fresh symbols are needed.
    feed(A,0); feed(A,0); feed(A,0); feed(A,1);
    chk("post_reset_count", 32'(match_count), 1);
    clr_count = 1'b1;
    feed(A,1);
    clr_count = 1'b0;
    chk("clr_beats_match", 32'(match_count), 0);

    @(negedge clock);
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
